mc_ctrl_fsm: RTL and testbench

- Parametrised next-generation multicycle MIPS control FSM. Drives datapath muxes, register-file and memory strobes, and the PC-enable.
- Over the current control unit, it adds:
  - a variable-latency memory handshake with timeout,
  - bne/andi/ori/jal support,
  - wider ALUOp/RegDst/MemtoReg selects,
  - sticky error flags.
- Sits between the instruction register opcode field, the ALU Zero flag and the datapath.

---
 rtl/mc_ctrl_pkg.sv | 66 ++++++
 rtl/mc_mem_wait_timer.sv | 28 ++
 rtl/mc_ctrl_fsm.sv | 218 +++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXEC     = 4'd6,
    RTYPEEND = 4'd7,
    BRANCH   = 4'd8,
    IEXEC    = 4'd9,
    IEND     = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    HALT     = 4'd13
  } state_t;

  // Primary opcode field values.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALUOp encodings.
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  // RegDst encodings.
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // MemtoReg encodings.
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // ALUSrcB encodings.
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PCSource encodings.
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // States that wait on the memory handshake.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Memory wait counter: counts consecutive cycles a memory-access state has
// been waiting on mem_ready and flags a timeout once the limit is reached.
module mc_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  logic [7:0] wait_cnt;

  // Count stalled cycles; leaving a wait state or a completed handshake clears it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset || !active || mem_ready) begin
      wait_cnt <= '0;
    end else if (wait_cnt != 8'(MEM_TIMEOUT)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // A handshake arriving in the limit cycle still wins over the timeout.
  assign timeout = active && !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory handshake timeout and sticky
// error flags. Optional perf counters are enabled by MC_CTRL_PERF_EN.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  Op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       RegDst,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [2:0]       ALUOp,
  output logic             PCSel,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] cycle_count
);

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic            pc_write, pc_write_cond, branch_ne;
  logic            decode_illegal;
  logic            timeout;

  mc_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (is_mem_wait_state(state_q)),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Opcode latched in DECODE so later states see a stable instruction class.
  always_ff @(posedge clk) begin
    // NOTE: op_q is a datapath holding register; it is always written before use, so it carries no reset.
    if (state_q == DECODE) op_q <= Op;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_op <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      if (decode_illegal) illegal_op <= 1'b1;
      if (timeout)        mem_err    <= 1'b1;
    end
  end

  // Next-state and Moore outputs; PCSel additionally folds in Zero.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d        = state_q;
    IorD           = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    IRWrite        = 1'b0;
    RegWrite       = 1'b0;
    ALUSrcA        = 1'b0;
    MemtoReg       = M2R_ALUOUT;
    RegDst         = RD_RT;
    ALUSrcB        = SRCB_B;
    PCSource       = PCS_ALU;
    ALUOp          = ALU_ADD;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    branch_ne      = 1'b0;
    decode_illegal = 1'b0;

    case (state_q)
      FETCH: begin
        MemRead  = 1'b1;
        IRWrite  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        pc_write = mem_ready;
        if (mem_ready)    state_d = DECODE;
        else if (timeout) state_d = HALT;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        if (Op == OP_W'(OP_LW) || Op == OP_W'(OP_SW))         state_d = MEMADR;
        else if (Op == OP_W'(OP_RTYPE))                         state_d = EXEC;
        else if (Op == OP_W'(OP_BEQ) || Op == OP_W'(OP_BNE))  state_d = BRANCH;
        else if (Op == OP_W'(OP_ADDI) || Op == OP_W'(OP_ANDI) ||
                 Op == OP_W'(OP_ORI))                           state_d = IEXEC;
        else if (Op == OP_W'(OP_J))                             state_d = JUMP;
        else if (Op == OP_W'(OP_JAL))                           state_d = JAL;
        else begin
          decode_illegal = 1'b1;
          state_d        = FETCH;
        end
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
        state_d = (op_q == OP_W'(OP_LW)) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready)    state_d = MEMWB;
        else if (timeout) state_d = HALT;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
        RegDst   = RD_RT;
        state_d  = FETCH;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready)    state_d = FETCH;
        else if (timeout) state_d = HALT;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
        state_d = RTYPEEND;
      end
      RTYPEEND: begin
        RegWrite = 1'b1;
        RegDst   = RD_RD;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALU_SUB;
        pc_write_cond = 1'b1;
        PCSource      = PCS_ALUOUT;
        branch_ne     = (op_q == OP_W'(OP_BNE));
        state_d       = FETCH;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (op_q == OP_W'(OP_ANDI))     ALUOp = ALU_AND;
        else if (op_q == OP_W'(OP_ORI)) ALUOp = ALU_OR;
        else                            ALUOp = ALU_ADD;
        state_d = IEND;
      end
      IEND: begin
        RegWrite = 1'b1;
        RegDst   = RD_RT;
        MemtoReg = M2R_ALUOUT;
        state_d  = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        PCSource = PCS_JUMP;
        state_d  = FETCH;
      end
      JAL: begin
        pc_write = 1'b1;
        PCSource = PCS_JUMP;
        RegWrite = 1'b1;
        RegDst   = RD_RA;
        MemtoReg = M2R_PC;
        state_d  = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    PCSel = pc_write | (pc_write_cond & (Zero ^ branch_ne));
  end

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] retired_q, cycles_q;
  logic             retire;

  // An instruction retires when FETCH is re-entered from any state past DECODE.
  assign retire = (state_d == FETCH) && (state_q != FETCH) && (state_q != DECODE);

  // Free-running perf counters, frozen once the FSM has halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      cycles_q  <= '0;
    end else if (state_q != HALT) begin
      cycles_q <= cycles_q + CNT_W'(1);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign instr_retired = retired_q;
  assign cycle_count   = cycles_q;
`else
  assign instr_retired = '0;
  assign cycle_count   = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the stimulus process drives one cycle at a
// time and queues the hand-computed expected outputs; a negedge monitor pops
// and compares. Counter expectations follow MC_CTRL_PERF_EN when defined.
module tb_mc_ctrl_fsm;

  localparam int OP_W        = 6;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [OP_W-1:0]  Op;
  logic             Zero;
  logic             mem_ready;
  logic             IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]       MemtoReg, RegDst, ALUSrcB, PCSource;
  logic [2:0]       ALUOp;
  logic             PCSel, illegal_op, mem_err;
  logic [CNT_W-1:0] instr_retired, cycle_count;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.OP_W(OP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .Op            (Op),
    .Zero          (Zero),
    .mem_ready     (mem_ready),
    .IorD          (IorD),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .ALUSrcA       (ALUSrcA),
    .MemtoReg      (MemtoReg),
    .RegDst        (RegDst),
    .ALUSrcB       (ALUSrcB),
    .PCSource      (PCSource),
    .ALUOp         (ALUOp),
    .PCSel         (PCSel),
    .illegal_op    (illegal_op),
    .mem_err       (mem_err),
    .instr_retired (instr_retired),
    .cycle_count   (cycle_count)
  );

  // Control vector layout:
  // {IorD,MemRead,MemWrite,IRWrite,RegWrite,ALUSrcA, MemtoReg,RegDst,ALUSrcB,PCSource, ALUOp, PCSel}
  logic [17:0] ctl_act;
  assign ctl_act = {IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                    MemtoReg, RegDst, ALUSrcB, PCSource, ALUOp, PCSel};

  localparam logic [17:0] E_FETCH_R = {6'b010100, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b1};
  localparam logic [17:0] E_FETCH_W = {6'b010100, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] E_DECODE  = {6'b000000, 2'b00, 2'b00, 2'b11, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] E_MEMADR  = {6'b000001, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] E_MEMRD   = {6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] E_MEMWB   = {6'b000010, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] E_MEMWR   = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] E_EXEC    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [17:0] E_RTEND   = {6'b000010, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] E_BR_T    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b01, 3'b001, 1'b1};
  localparam logic [17:0] E_BR_N    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b01, 3'b001, 1'b0};
  localparam logic [17:0] E_IADD    = {6'b000001, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] E_IAND    = {6'b000001, 2'b00, 2'b00, 2'b10, 2'b00, 3'b011, 1'b0};
  localparam logic [17:0] E_IOR     = {6'b000001, 2'b00, 2'b00, 2'b10, 2'b00, 3'b100, 1'b0};
  localparam logic [17:0] E_IEND    = {6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] E_JUMP    = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 1'b1};
  localparam logic [17:0] E_JAL     = {6'b000010, 2'b10, 2'b10, 2'b00, 2'b10, 3'b000, 1'b1};
  localparam logic [17:0] E_HALT    = 18'd0;

  // Scoreboard queues, one entry per checked cycle.
  string            nm_q[$];
  logic [17:0]      ctl_q[$];
  logic [1:0]       flg_q[$];   // {illegal_op, mem_err}
  logic [CNT_W-1:0] ret_q[$];
  logic [CNT_W-1:0] cyc_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int nret    = 0;
  int ncyc    = 0;

  task automatic check(input string nm, input string what,
                       input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got %h expected %h", nm, what, act, exp);
  endtask

  // Monitor: compares the DUT outputs mid-cycle against the queued expectation.
  string            m_nm;
  logic [17:0]      m_ctl;
  logic [1:0]       m_flg;
  logic [CNT_W-1:0] m_ret, m_cyc;
  always @(negedge clk) begin
    if (nm_q.size() != 0) begin
      m_nm  = nm_q.pop_front();
      m_ctl = ctl_q.pop_front();
      m_flg = flg_q.pop_front();
      m_ret = ret_q.pop_front();
      m_cyc = cyc_q.pop_front();
      check(m_nm, "ctl",   64'(ctl_act), 64'(m_ctl));
      check(m_nm, "flags", 64'({illegal_op, mem_err}), 64'(m_flg));
      check(m_nm, "ctrs",  {instr_retired, cycle_count}, {m_ret, m_cyc});
    end
  end

  // Drive one cycle's inputs, queue its expectation, then advance to the next cycle.
  task automatic step(input string nm, input logic [5:0] op, input logic z,
                      input logic rdy, input logic [17:0] e, input logic [1:0] flg,
                      input bit retire, input bit halted);
    Op        = op;
    Zero      = z;
    mem_ready = rdy;
    nm_q.push_back(nm);
    ctl_q.push_back(e);
    flg_q.push_back(flg);
`ifdef MC_CTRL_PERF_EN
    ret_q.push_back(CNT_W'(nret));
    cyc_q.push_back(CNT_W'(ncyc));
`else
    ret_q.push_back('0);
    cyc_q.push_back('0);
`endif
    if (retire)  nret++;
    if (!halted) ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    nret  = 0;
    ncyc  = 0;
  endtask

  // Four-cycle instruction: FETCH, DECODE, execute state, completion state.
  task automatic instr4(input string nm, input logic [5:0] op, input logic z,
                        input logic [17:0] e3, input logic [17:0] e4, input logic [1:0] flg);
    step({nm, "_fetch"},  op, z, 1'b1, E_FETCH_R, flg, 1'b0, 1'b0);
    step({nm, "_decode"}, op, z, 1'b1, E_DECODE,  flg, 1'b0, 1'b0);
    step({nm, "_s3"},     op, z, 1'b1, e3,        flg, 1'b0, 1'b0);
    step({nm, "_s4"},     op, z, 1'b1, e4,        flg, 1'b1, 1'b0);
  endtask

  // Three-cycle instruction: FETCH, DECODE, completion state.
  task automatic instr3(input string nm, input logic [5:0] op, input logic z,
                        input logic [17:0] e3, input logic [1:0] flg);
    step({nm, "_fetch"},  op, z, 1'b1, E_FETCH_R, flg, 1'b0, 1'b0);
    step({nm, "_decode"}, op, z, 1'b1, E_DECODE,  flg, 1'b0, 1'b0);
    step({nm, "_s3"},     op, z, 1'b1, e3,        flg, 1'b1, 1'b0);
  endtask

  initial begin
    Op        = '0;
    Zero      = 1'b0;
    mem_ready = 1'b1;
    do_reset();

    // lw with immediate memory: five cycles, write-back only in MEMWB.
    step("lw_fetch",  6'h23, 1'b0, 1'b1, E_FETCH_R, 2'b00, 1'b0, 1'b0);
    step("lw_decode", 6'h23, 1'b0, 1'b1, E_DECODE,  2'b00, 1'b0, 1'b0);
    step("lw_memadr", 6'h23, 1'b0, 1'b1, E_MEMADR,  2'b00, 1'b0, 1'b0);
    step("lw_memrd",  6'h23, 1'b0, 1'b1, E_MEMRD,   2'b00, 1'b0, 1'b0);
    step("lw_memwb",  6'h23, 1'b0, 1'b1, E_MEMWB,   2'b00, 1'b1, 1'b0);

    instr4("sw",   6'h2B, 1'b0, E_MEMADR, E_MEMWR, 2'b00);
    instr4("rtyp", 6'h00, 1'b0, E_EXEC,   E_RTEND, 2'b00);
    instr4("addi", 6'h08, 1'b0, E_IADD,   E_IEND,  2'b00);
    instr4("andi", 6'h0C, 1'b0, E_IAND,   E_IEND,  2'b00);
    instr4("ori",  6'h0D, 1'b0, E_IOR,    E_IEND,  2'b00);

    instr3("beq_z1", 6'h04, 1'b1, E_BR_T, 2'b00);
    instr3("beq_z0", 6'h04, 1'b0, E_BR_N, 2'b00);
    instr3("bne_z0", 6'h05, 1'b0, E_BR_T, 2'b00);
    instr3("bne_z1", 6'h05, 1'b1, E_BR_N, 2'b00);
    instr3("j",      6'h02, 1'b0, E_JUMP, 2'b00);
    instr3("jal",    6'h03, 1'b0, E_JAL,  2'b00);

    // FETCH stalls three cycles; PC enable only in the fourth.
    for (int i = 0; i < 3; i++)
      step("fwait_stall", 6'h02, 1'b0, 1'b0, E_FETCH_W, 2'b00, 1'b0, 1'b0);
    step("fwait_fetch",  6'h02, 1'b0, 1'b1, E_FETCH_R, 2'b00, 1'b0, 1'b0);
    step("fwait_decode", 6'h02, 1'b0, 1'b1, E_DECODE,  2'b00, 1'b0, 1'b0);
    step("fwait_jump",   6'h02, 1'b0, 1'b1, E_JUMP,    2'b00, 1'b1, 1'b0);

    // MEMRD: ready arriving exactly at the limit cycle is a success.
    step("lwb_fetch",  6'h23, 1'b0, 1'b1, E_FETCH_R, 2'b00, 1'b0, 1'b0);
    step("lwb_decode", 6'h23, 1'b0, 1'b1, E_DECODE,  2'b00, 1'b0, 1'b0);
    step("lwb_memadr", 6'h23, 1'b0, 1'b1, E_MEMADR,  2'b00, 1'b0, 1'b0);
    for (int i = 0; i < MEM_TIMEOUT; i++)
      step("lwb_memrd_stall", 6'h23, 1'b0, 1'b0, E_MEMRD, 2'b00, 1'b0, 1'b0);
    step("lwb_memrd_ready", 6'h23, 1'b0, 1'b1, E_MEMRD, 2'b00, 1'b0, 1'b0);
    step("lwb_memwb",       6'h23, 1'b0, 1'b1, E_MEMWB, 2'b00, 1'b1, 1'b0);

    // Illegal opcode: back to FETCH, sticky flag, no retirement.
    step("ill_fetch",  6'h3F, 1'b0, 1'b1, E_FETCH_R, 2'b00, 1'b0, 1'b0);
    step("ill_decode", 6'h3F, 1'b0, 1'b1, E_DECODE,  2'b00, 1'b0, 1'b0);
    instr4("post_ill", 6'h00, 1'b0, E_EXEC, E_RTEND, 2'b10);

    do_reset();

    // sw timeout: limit+1 stalled MEMWR cycles, then HALT with mem_err.
    step("to_fetch",  6'h2B, 1'b0, 1'b1, E_FETCH_R, 2'b00, 1'b0, 1'b0);
    step("to_decode", 6'h2B, 1'b0, 1'b1, E_DECODE,  2'b00, 1'b0, 1'b0);
    step("to_memadr", 6'h2B, 1'b0, 1'b1, E_MEMADR,  2'b00, 1'b0, 1'b0);
    for (int i = 0; i <= MEM_TIMEOUT; i++)
      step("to_memwr", 6'h2B, 1'b0, 1'b0, E_MEMWR, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("halt", 6'h00, 1'b1, 1'b1, E_HALT, 2'b01, 1'b0, 1'b1);

    do_reset();

    // After reset the flags are clear and the FSM runs again.
    step("rst_lw_fetch",  6'h23, 1'b0, 1'b1, E_FETCH_R, 2'b00, 1'b0, 1'b0);
    step("rst_lw_decode", 6'h23, 1'b0, 1'b1, E_DECODE,  2'b00, 1'b0, 1'b0);
    step("rst_lw_memadr", 6'h23, 1'b0, 1'b1, E_MEMADR,  2'b00, 1'b0, 1'b0);
    step("rst_lw_memrd",  6'h23, 1'b0, 1'b1, E_MEMRD,   2'b00, 1'b0, 1'b0);
    step("rst_lw_memwb",  6'h23, 1'b0, 1'b1, E_MEMWB,   2'b00, 1'b1, 1'b0);

    for (int i = 0; i < 10 && nm_q.size() != 0; i++) @(posedge clk);
    if (nm_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", nm_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
